// File: rtl/j1_wb_pkg.sv
// Shared types and defaults for the J1 ibus/dbus to Wishbone bridge.
package j1_wb_pkg;

    typedef enum logic [1:0] {IDLE, DCYC, ICYC} state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/j1_wb_timeout.sv
// Wait-state counter for one Wishbone cycle; expired marks the last cycle allowed.
module j1_wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

            logic [CW-1:0] cnt;

            // Saturating so a stuck enable can never wrap back into range.
            always_ff @(posedge clk) begin
                if (!reset || clr) begin
                    cnt <= '0;
                end else if (en && cnt != SAT) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = en && (cnt == LAST);
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/j1_wb_bridge.sv
// Registered Wishbone B4 classic master shared by the J1 fetch and data buses.
// state | meaning
// IDLE  | no Wishbone cycle, waiting for a request
// DCYC  | data-bus access in flight
// ICYC  | instruction fetch in flight
module j1_wb_bridge
    import j1_wb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int TIMEOUT    = 255,
    parameter int DBUS_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ibus_re,
    input  logic [AW-1:0]            ibus_adr,
    output logic [DW-1:0]            ibus_dat_i,
    output logic                     ibus_done,
    input  logic                     dbus_re,
    input  logic                     dbus_we,
    input  logic [AW-1:0]            dbus_adr,
    input  logic [DW-1:0]            dbus_dat_o,
    output logic [DW-1:0]            dbus_dat_i,
    output logic                     dbus_done,
    output logic                     core_stall,
    output logic [AW-1:0]            wb_adr_o,
    output logic [DW-1:0]            wb_dat_o,
    input  logic [DW-1:0]            wb_dat_i,
    output logic                     wb_we_o,
    output logic [sel_width(DW)-1:0] wb_sel_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    output logic                     bus_error,
    output logic [AW-1:0]            err_adr,
    input  logic                     err_clr
);

    state_t state;
    logic   served_d, served_i;
    logic   dreq, ireq, active, expired, term, fail;
    logic   start_d, start_i, stop;

    // A bus already served while the core is still stalled must not be replayed.
    assign dreq   = (dbus_re | dbus_we) & ~served_d;
    assign ireq   = ibus_re & ~served_i;
    assign active = reset && (state != IDLE);
    assign term   = active && (wb_ack_i || wb_err_i || expired);
    assign fail   = active && (wb_err_i || (expired && !wb_ack_i));

    assign dbus_done  = term && (state == DCYC);
    assign ibus_done  = term && (state == ICYC);
    assign dbus_dat_i = (dbus_done && !fail) ? wb_dat_i : '0;
    assign ibus_dat_i = (ibus_done && !fail) ? wb_dat_i : '0;
    assign core_stall = (dreq && !dbus_done) || (ireq && !ibus_done);

    assign start_d = (state == IDLE) ? (dreq && (DBUS_FIRST != 0 || !ireq)) : (ibus_done && dreq);
    assign start_i = (state == IDLE) ? (ireq && !start_d) : (dbus_done && ireq);
    assign stop    = term && !start_d && !start_i;

    j1_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (term),
        .en      (state != IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            served_d  <= 1'b0;
            served_i  <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            bus_error <= 1'b0;
            err_adr   <= '0;
        end else begin
            served_d <= core_stall && (served_d || dbus_done);
            served_i <= core_stall && (served_i || ibus_done);

            // A fresh failure beats a simultaneous clear.
            if (fail && (!bus_error || err_clr)) begin
                bus_error <= 1'b1;
                err_adr   <= wb_adr_o;
            end else if (err_clr) begin
                bus_error <= 1'b0;
                err_adr   <= '0;
            end

            if (start_d) begin
                state    <= DCYC;
                wb_adr_o <= dbus_adr;
                wb_we_o  <= dbus_we;
                wb_dat_o <= dbus_dat_o;
                wb_sel_o <= '1;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
            end else if (start_i) begin
                state    <= ICYC;
                wb_adr_o <= ibus_adr;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '1;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
            end else if (stop) begin
                state    <= IDLE;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
                wb_stb_o <= 1'b0;
                wb_cyc_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_j1_wb_bridge.sv
// Bench for j1_wb_bridge: randomized core/slave traffic against a transaction-level model.
module tb_j1_wb_bridge;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        ibus_re = 1'b0, dbus_re = 1'b0, dbus_we = 1'b0, err_clr = 1'b0;
    logic [15:0] ibus_adr = '0, dbus_adr = '0, dbus_dat_o = '0;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    logic [15:0] a_idat, a_ddat, a_adr, a_wdat, a_eadr, b_idat, b_ddat, b_adr, b_wdat, b_eadr;
    logic        a_idone, a_ddone, a_stall, a_we, a_stb, a_cyc, a_berr;
    logic        b_idone, b_ddone, b_stall, b_we, b_stb, b_cyc, b_berr;
    logic [1:0]  a_sel, b_sel;

    logic [15:0] m_idat, m_ddat, m_adr, m_wdat, m_eadr;
    logic        m_idone, m_ddone, m_stall, m_we, m_stb, m_cyc, m_berr;
    logic [1:0]  m_sel;

    assign m_idat  = sel ? b_idat  : a_idat;
    assign m_ddat  = sel ? b_ddat  : a_ddat;
    assign m_adr   = sel ? b_adr   : a_adr;
    assign m_wdat  = sel ? b_wdat  : a_wdat;
    assign m_eadr  = sel ? b_eadr  : a_eadr;
    assign m_idone = sel ? b_idone : a_idone;
    assign m_ddone = sel ? b_ddone : a_ddone;
    assign m_stall = sel ? b_stall : a_stall;
    assign m_we    = sel ? b_we    : a_we;
    assign m_stb   = sel ? b_stb   : a_stb;
    assign m_cyc   = sel ? b_cyc   : a_cyc;
    assign m_berr  = sel ? b_berr  : a_berr;
    assign m_sel   = sel ? b_sel   : a_sel;

    j1_wb_bridge #(.TIMEOUT(TO), .DBUS_FIRST(1)) dut_a (
        .clk(clk), .reset(reset),
        .ibus_re(ibus_re & ~sel), .ibus_adr(ibus_adr), .ibus_dat_i(a_idat), .ibus_done(a_idone),
        .dbus_re(dbus_re & ~sel), .dbus_we(dbus_we & ~sel), .dbus_adr(dbus_adr),
        .dbus_dat_o(dbus_dat_o), .dbus_dat_i(a_ddat), .dbus_done(a_ddone), .core_stall(a_stall),
        .wb_adr_o(a_adr), .wb_dat_o(a_wdat), .wb_dat_i(wb_dat_i), .wb_we_o(a_we), .wb_sel_o(a_sel),
        .wb_stb_o(a_stb), .wb_cyc_o(a_cyc), .wb_ack_i(wb_ack & ~sel), .wb_err_i(wb_err & ~sel),
        .bus_error(a_berr), .err_adr(a_eadr), .err_clr(err_clr & ~sel)
    );

    j1_wb_bridge #(.TIMEOUT(TO), .DBUS_FIRST(0)) dut_b (
        .clk(clk), .reset(reset),
        .ibus_re(ibus_re & sel), .ibus_adr(ibus_adr), .ibus_dat_i(b_idat), .ibus_done(b_idone),
        .dbus_re(dbus_re & sel), .dbus_we(dbus_we & sel), .dbus_adr(dbus_adr),
        .dbus_dat_o(dbus_dat_o), .dbus_dat_i(b_ddat), .dbus_done(b_ddone), .core_stall(b_stall),
        .wb_adr_o(b_adr), .wb_dat_o(b_wdat), .wb_dat_i(wb_dat_i), .wb_we_o(b_we), .wb_sel_o(b_sel),
        .wb_stb_o(b_stb), .wb_cyc_o(b_cyc), .wb_ack_i(wb_ack & sel), .wb_err_i(wb_err & sel),
        .bus_error(b_berr), .err_adr(b_eadr), .err_clr(err_clr & sel)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] rd_fn(input logic [15:0] a);
        if (a == 16'h0100) return 16'h8005;
        return {a[7:0], a[15:8]} ^ 16'h1357;
    endfunction

    // Slave configuration for the current transaction, keyed by which address it sees.
    logic [15:0] cfg_dadr = '0;
    int          d_wait = 0, i_wait = 0;
    bit          d_fail = 0, i_fail = 0, d_noack = 0, i_noack = 0, stray = 0;
    logic [15:0] log_adr[$];
    logic [15:0] log_dat[$];
    bit          log_we[$];

    // Reference error state.
    bit          m_err = 0;
    logic [15:0] m_err_adr = '0;

    initial begin
        int          wc;
        bit          isd, prev_stb;
        logic [15:0] prev_adr;
        wc = 0;
        prev_stb = 0;
        prev_adr = '0;
        forever begin
            @(posedge clk);
            #2;
            if (m_stb) begin
                if (!prev_stb || m_adr != prev_adr) begin
                    wc = 0;
                    log_adr.push_back(m_adr);
                    log_we.push_back(m_we);
                    log_dat.push_back(m_wdat);
                    chk("sel", 32'(m_sel), 32'(2'b11));
                end
                isd = (m_adr == cfg_dadr);
                if (!(isd ? d_noack : i_noack) && wc == (isd ? d_wait : i_wait)) begin
                    wb_ack   = 1'b1;
                    wb_err   = isd ? d_fail : i_fail;
                    wb_dat_i = rd_fn(m_adr);
                end else begin
                    wb_ack   = stray;
                    wb_err   = 1'b0;
                    wb_dat_i = 16'($urandom);
                    wc++;
                end
            end else begin
                wb_ack   = stray;
                wb_err   = 1'b0;
                wb_dat_i = 16'($urandom);
            end
            prev_stb = m_stb;
            prev_adr = m_adr;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cyc"}, 32'(m_cyc), 0);
        chk({tag, "_stb"}, 32'(m_stb), 0);
        chk({tag, "_we"}, 32'(m_we), 0);
        chk({tag, "_sel"}, 32'(m_sel), 0);
        chk({tag, "_adr"}, 32'(m_adr), 0);
        chk({tag, "_wdat"}, 32'(m_wdat), 0);
        chk({tag, "_berr"}, 32'(m_berr), 0);
        chk({tag, "_eadr"}, 32'(m_eadr), 0);
        chk({tag, "_done"}, 32'({m_ddone, m_idone}), 0);
    endtask

    // One core transaction; expectations come from simple per-access latency arithmetic.
    task automatic run_txn(input bit dv, input bit dwr, input logic [15:0] da, input logic [15:0] dd,
                           input bit iv, input logic [15:0] ia, input int dwt, input int iwt,
                           input bit dfl, input bit ifl, input bit dna, input bit ina);
        int          td, ti, tl, dlen, ilen, c, nd, ni, stalls, gtd, gti;
        bit          d_first, done, f;
        logic [15:0] gd, gi, ed, ei;
        logic [15:0] e_adr[$];
        bit          e_we[$];
        cfg_dadr = dv ? da : ~ia;
        d_wait = dwt; i_wait = iwt; d_fail = dfl; i_fail = ifl; d_noack = dna; i_noack = ina;
        log_adr.delete(); log_we.delete(); log_dat.delete();

        d_first = dv && (!iv || !sel);
        dlen = dna ? TO - 1 : dwt;
        ilen = ina ? TO - 1 : iwt;
        td = -1; ti = -1;
        if (d_first) begin
            td = 1 + dlen; tl = td;
            e_adr.push_back(da); e_we.push_back(dwr);
            if (iv) begin ti = tl + 1 + ilen; tl = ti; e_adr.push_back(ia); e_we.push_back(0); end
        end else begin
            ti = 1 + ilen; tl = ti;
            e_adr.push_back(ia); e_we.push_back(0);
            if (dv) begin td = tl + 1 + dlen; tl = td; e_adr.push_back(da); e_we.push_back(dwr); end
        end
        for (int k = 0; k < e_adr.size(); k++) begin
            f = (e_adr[k] == da && dv) ? (dna || dfl) : (ina || ifl);
            if (f && !m_err) begin m_err = 1; m_err_adr = e_adr[k]; end
        end
        ed = (dna || dfl) ? 16'h0 : rd_fn(da);
        ei = (ina || ifl) ? 16'h0 : rd_fn(ia);

        @(posedge clk); #1;
        dbus_re = dv & ~dwr; dbus_we = dv & dwr; dbus_adr = da; dbus_dat_o = dd;
        ibus_re = iv; ibus_adr = ia;
        c = 0; nd = 0; ni = 0; stalls = 0; gtd = -1; gti = -1; gd = '0; gi = '0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (m_ddone) begin nd++; gtd = c; gd = m_ddat; end
            if (m_idone) begin ni++; gti = c; gi = m_idat; end
            if (m_stall) stalls++;
            else done = 1;
            c++;
            if (!done && c > 40) begin chk("txn_bound", 32'(c), 0); done = 1; end
        end
        @(posedge clk); #1;
        dbus_re = 0; dbus_we = 0; ibus_re = 0;
        @(negedge clk);
        chk("cyc_after", 32'(m_cyc), 0);
        chk("bus_error", 32'(m_berr), 32'(m_err));
        chk("err_adr", 32'(m_eadr), 32'(m_err_adr));
        chk("stall_cycles", 32'(stalls), 32'(tl));
        if (dv) begin
            chk("d_done_cyc", 32'(gtd), 32'(td));
            chk("d_done_cnt", 32'(nd), 1);
            if (!dwr) chk("d_rdata", 32'(gd), 32'(ed));
        end else chk("d_no_done", 32'(nd), 0);
        if (iv) begin
            chk("i_done_cyc", 32'(gti), 32'(ti));
            chk("i_done_cnt", 32'(ni), 1);
            chk("i_rdata", 32'(gi), 32'(ei));
        end else chk("i_no_done", 32'(ni), 0);
        chk("wb_cycles", 32'(log_adr.size()), 32'(e_adr.size()));
        for (int k = 0; k < e_adr.size() && k < log_adr.size(); k++) begin
            chk("wb_adr", 32'(log_adr[k]), 32'(e_adr[k]));
            chk("wb_we", 32'(log_we[k]), 32'(e_we[k]));
            if (e_we[k]) chk("wb_wdat", 32'(log_dat[k]), 32'(dd));
        end
    endtask

    task automatic clear_err();
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        m_err = 0; m_err_adr = '0;
        @(negedge clk);
        chk("clr_berr", 32'(m_berr), 0);
        chk("clr_eadr", 32'(m_eadr), 0);
    endtask

    task automatic stray_idle();
        @(posedge clk); #1 stray = 1;
        @(negedge clk);
        chk("stray_done", 32'({m_ddone, m_idone}), 0);
        @(posedge clk); #1 stray = 0;
        @(negedge clk);
        chk("stray_cyc", 32'(m_cyc), 0);
    endtask

    task automatic random_txns(input int n);
        bit          dv, iv, dwr;
        int          kind;
        logic [15:0] da, ia;
        for (int t = 0; t < n; t++) begin
            kind = $urandom_range(0, 2);
            dv = (kind != 0); iv = (kind != 1);
            dwr = $urandom_range(0, 1) == 1;
            da = 16'($urandom); ia = 16'($urandom);
            if (ia == da) ia = ia ^ 16'h0001;
            run_txn(dv, dwr, da, 16'($urandom), iv, ia,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) clear_err();
            if ($urandom_range(0, 5) == 0) stray_idle();
        end
    endtask

    initial begin
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1 reset = 1;

        run_txn(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 0, 3, 0, 0, 0, 0);
        run_txn(1, 0, 16'h2000, 16'h0000, 1, 16'h0042, 0, 0, 0, 0, 0, 0);
        run_txn(1, 0, 16'h1234, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 0);
        run_txn(1, 0, 16'h5678, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 0);
        clear_err();
        run_txn(1, 0, 16'h3000, 16'h0000, 0, 16'h0000, 1, 0, 1, 0, 0, 0);
        stray_idle();

        // Reset while a data read is waiting on a silent slave.
        cfg_dadr = 16'h0777; d_noack = 1;
        @(posedge clk); #1 dbus_re = 1; dbus_adr = 16'h0777;
        repeat (3) @(posedge clk);
        #1 reset = 0; stray = 1;
        @(negedge clk);
        chk("rst_mid_done", 32'({m_ddone, m_idone}), 0);
        @(posedge clk); #1 reset = 1; dbus_re = 0;
        m_err = 0; m_err_adr = '0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        chk("rst_mid_stall", 32'(m_stall), 0);
        @(posedge clk); #1 stray = 0;

        random_txns(40);

        sel = 1;
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 reset = 1;
        m_err = 0; m_err_adr = '0;
        run_txn(1, 0, 16'h2000, 16'h0000, 1, 16'h0042, 0, 0, 0, 0, 0, 0);
        run_txn(1, 1, 16'h4444, 16'h1111, 1, 16'h0100, 2, 1, 0, 0, 0, 0);
        random_txns(15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/j1_wb_bridge.md
Name: j1_wb_bridge

Overview:
- Registered Wishbone B4 classic master joining the J1 core's instruction bus (ibus) and data bus (dbus) to one shared Wishbone port.
- Supports slaves with arbitrary wait states.
  - The core is held with core_stall until the access completes.
- Arbitrates simultaneous fetch and data accesses.
- Adds a bus timeout and sticky error capture.
- Sits between j1_core and the system interconnect.
  - Successor to the zero-wait-state combinational glue.

Parameters:
- AW, 16, Wishbone/core word address width.
- DW, 16, data width. Multiple of 8.
- TIMEOUT, 255, maximum cycles an access may wait for ack/err. 0 disables the timeout.
- DBUS_FIRST, 1, when both buses request: 1 = data access first, 0 = fetch first.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ibus_re  in  1  fetch request. Held by the core while core_stall=1.
- ibus_adr  in  AW  fetch address.
- ibus_dat_i  out  DW  fetched instruction. Valid when ibus_done=1.
- ibus_done  out  1  fetch completes this cycle.
- dbus_re  in  1  data read request.
- dbus_we  in  1  data write request. dbus_re and dbus_we are never both 1.
- dbus_adr  in  AW  data address.
- dbus_dat_o  in  DW  write data.
- dbus_dat_i  out  DW  read data. Valid when dbus_done=1.
- dbus_done  out  1  data access completes this cycle.
- core_stall  out  1  core must hold all request signals and not advance.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_dat_i  in  DW  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  DW/8  byte selects. All ones during a cycle, else 0.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- bus_error  out  1  sticky: an err or timeout has occurred.
- err_adr  out  AW  address of the first failing access.
- err_clr  in  1  clears bus_error and err_adr.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o = 0.
  - wb_adr_o, wb_dat_o = 0.
  - bus_error = 0, err_adr = 0.
  - Timeout counter = 0.
  - Done outputs = 0.
- Reset mid-cycle: cyc/stb drop at that edge. No done pulse. A late ack is ignored.
- FSM states: IDLE, DCYC, ICYC. All Wishbone outputs are registered.
- IDLE:
  - If a data request is present (dbus_re|dbus_we) and (DBUS_FIRST=1 or ibus_re=0): go to DCYC.
    - Load wb_adr_o=dbus_adr, wb_we_o=dbus_we, wb_dat_o=dbus_dat_o.
    - Set cyc=stb=1.
  - Else if ibus_re: go to ICYC.
    - Load wb_adr_o=ibus_adr, wb_we_o=0.
    - Set cyc=stb=1.
- DCYC/ICYC: outputs are held. The timeout counter increments each cycle.
- A cycle terminates on wb_ack_i, wb_err_i, or counter==TIMEOUT-1 (TIMEOUT>0). wb_err_i has priority over ack.
- On termination:
  - cyc/stb/we deassert at the next edge.
  - Counter clears.
  - The matching done signal is 1 in the termination cycle (combinational from ack/err).
  - Read data = wb_dat_i on ack, all-zero on err or timeout.
  - Next state: the other bus's cycle if it still requests, else IDLE.
    - The loaded address and data for that cycle are taken at this edge, with no idle cycle in between.
    - A terminating DCYC followed by a pending fetch goes to ICYC, and vice versa.
- A bus that just completed is not re-issued back-to-back. It must pass through IDLE or the other bus's cycle first.
  - This prevents replaying a completed request the core has not yet dropped.
- core_stall = (any request present) AND NOT (every present request completes this cycle). It is combinational.
  - Minimum latency with a zero-wait slave (ack in the first stb cycle): request at cycle N, stb at N+1, done and stall=0 at N+1.
  - Each Wishbone wait state adds one cycle.
  - Both requests present: stall holds through both cycles. It is released only in the cycle the second completes.
- Error capture:
  - On err or timeout with bus_error=0: set bus_error=1 and capture err_adr=wb_adr_o.
  - Later errors do not overwrite.
  - err_clr=1 clears both. A simultaneous new error wins: it sets and captures.
- Stray wb_ack_i or wb_err_i in IDLE is ignored.
- The counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Package j1_wb_pkg holds:
  - the state enum typedef (IDLE/DCYC/ICYC);
  - the default AW/DW constants;
  - a helper function for the sel width.
- Sub-module j1_wb_timeout: counter with clear, enable and expired outputs, parametrised by TIMEOUT. With TIMEOUT=0, expired is tied to 0.

Test Plan:
- Zero-wait slave, dbus_we=1 to adr 0x0010 with data 0xBEEF:
  - cyc/stb/we at N+1 with adr 0x0010 and dat 0xBEEF.
  - dbus_done=1 and core_stall=0 at N+1.
  - cyc=0 at N+2.
- Slave adds 3 wait states on an ibus read of 0x0100 returning 0x8005:
  - core_stall=1 for 4 cycles.
  - ibus_done and ibus_dat_i=0x8005 in the ack cycle.
- dbus_re (0x2000) and ibus_re (0x0042) together, DBUS_FIRST=1:
  - DCYC then ICYC back-to-back with no idle cycle.
  - Stall is released only at the second ack.
  - Repeat with DBUS_FIRST=0: order reversed.
- No ack, TIMEOUT=8, access at 0x1234:
  - Termination after 8 stb cycles, read data 0.
  - bus_error=1, err_adr=0x1234.
  - A second error at 0x5678 leaves err_adr unchanged.
  - err_clr clears both.
- wb_err_i together with wb_ack_i on a read: error path taken, data 0, bus_error set.
- reset=0 asserted during a wait state:
  - cyc/stb=0 after the edge.
  - A subsequent stray ack produces no done pulse.
  - All outputs are at their reset values.
